// File: rtl/scanner_pkg.sv
// Shared types and constants for the 4-channel mux scanner.
package scanner_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search: first enabled channel strictly after cur_ch, wrapping.
// If cur_ch is the only enabled channel, it is returned again.
module rr_next_ch
    import scanner_pkg::*;
(
    input  logic [CH_W-1:0]   cur_ch,
    input  logic [NUM_CH-1:0] en_mask,
    output logic [CH_W-1:0]   nxt_ch,
    output logic              any_en
);

    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        nxt_ch = cur_ch;
        found  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = cur_ch + CH_W'(i);
            if (!found && en_mask[idx]) begin
                nxt_ch = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_en = |en_mask;

endmodule

// File: rtl/channel_scanner.sv
// Steps a 4:1 mux through the enabled channels, settles for dwell+1 cycles,
// then captures mux_out into a per-channel bit vector with a one-cycle strobe.
module channel_scanner
    import scanner_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NUM_CH-1:0]  en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               mux_out,
    output logic               S0,
    output logic               S1,
    output logic               busy,
    output logic               sample_valid,
    output logic [CH_W-1:0]    sample_ch,
    output logic [NUM_CH-1:0]  sample_bits
);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [NUM_CH-1:0]   bits_q, bits_d;

    logic [CH_W-1:0]     search_cur;
    logic [CH_W-1:0]     nxt_ch;
    logic                any_en;

    // Searching from the last channel yields the lowest enabled one at scan start.
    assign search_cur = (state_q == ST_IDLE) ? CH_W'(NUM_CH - 1) : sel_q;

    rr_next_ch u_rr_next_ch (
        .cur_ch  (search_cur),
        .en_mask (en_mask),
        .nxt_ch  (nxt_ch),
        .any_en  (any_en)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        ch_d    = ch_q;
        bits_d  = bits_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop && any_en) begin
                    state_d = ST_SETTLE;
                    sel_d   = nxt_ch;
                    cnt_d   = dwell;
                end
            end
            ST_SETTLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    bits_d[sel_q] = mux_out;
                    ch_d          = sel_q;
                    valid_d       = 1'b1;
                    if (any_en) begin
                        state_d = ST_SETTLE;
                        sel_d   = nxt_ch;
                        cnt_d   = dwell;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            bits_q  <= bits_d;
        end
    end

    assign S0           = sel_q[1];
    assign S1           = sel_q[0];
    assign busy         = (state_q != ST_IDLE);
    assign sample_valid = valid_q;
    assign sample_ch    = ch_q;
    assign sample_bits  = bits_q;

endmodule

// File: tb/tb_channel_scanner.sv
// Directed bench for channel_scanner: a behavioural 4:1 mux feeds mux_out and
// expected captures are queued at stimulus time, then checked on each strobe.
module tb_channel_scanner;
    import scanner_pkg::*;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          stop;
    logic [3:0]    en_mask;
    logic [DW-1:0] dwell;
    logic          mux_out;
    logic          S0, S1, busy, sample_valid;
    logic [1:0]    sample_ch;
    logic [3:0]    sample_bits;
    logic [3:0]    mux_in;

    typedef struct packed {
        logic [1:0] ch;
        logic [3:0] bits;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    assign mux_out = mux_in[{S0, S1}];

    always #5 clk = ~clk;

    channel_scanner #(.DWELL_W(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .en_mask      (en_mask),
        .dwell        (dwell),
        .mux_out      (mux_out),
        .S0           (S0),
        .S1           (S1),
        .busy         (busy),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_bits  (sample_bits)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] ch, input logic [3:0] bits);
        exp_t e;
        e.ch   = ch;
        e.bits = bits;
        sb.push_back(e);
    endtask

    // Every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sample_valid === 1'b1) begin
            check("strobe_expected", 8'(sb.size() > 0), 8'd1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("strobe_ch", 8'(sample_ch), 8'(mon_e.ch));
                check("strobe_bits", 8'(sample_bits), 8'(mon_e.bits));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        en_mask = 4'h0;
        dwell   = '0;
        mux_in  = 4'h0;
        #1;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_sel", 8'({S0, S1}), 8'd0);
        check("rst_valid", 8'(sample_valid), 8'd0);
        check("rst_ch", 8'(sample_ch), 8'd0);
        check("rst_bits", 8'(sample_bits), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 8'(busy), 8'd0);

        // Basic scan over all four channels, dwell=2 -> period 4.
        dwell   = 4'd2;
        en_mask = 4'b1111;
        mux_in  = 4'b1101;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s1_first_sel", 8'({S0, S1}), 8'd0);
        check("s1_busy", 8'(busy), 8'd1);
        push(2'd0, 4'b0001);
        push(2'd1, 4'b0001);
        push(2'd2, 4'b0101);
        push(2'd3, 4'b1101);
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            check("s1_valid", 8'(sample_valid), 8'(cyc % 4 == 0));
            if (cyc % 4 == 0)
                check("s1_sel", 8'({S0, S1}), 8'((cyc / 4) % 4));
        end
        check("s1_bits", 8'(sample_bits), 8'b1101);

        // Stop in the SAMPLE cycle of ch1 suppresses the capture.
        push(2'd0, 4'b1101);
        repeat (4) @(negedge clk);
        check("s4_sel_ch1", 8'({S0, S1}), 8'd1);
        mux_in = 4'b1111;
        repeat (3) @(negedge clk);
        check("s4_in_sample_busy", 8'(busy), 8'd1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("s4_stop_busy", 8'(busy), 8'd0);
        check("s4_stop_valid", 8'(sample_valid), 8'd0);
        check("s4_stop_bits", 8'(sample_bits), 8'b1101);
        check("s4_stop_sel", 8'({S0, S1}), 8'd1);
        @(negedge clk);
        check("s4_no_late_valid", 8'(sample_valid), 8'd0);

        // start and stop together in IDLE, then start with an empty mask.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("s4_startstop_busy", 8'(busy), 8'd0);
        check("s4_startstop_sel", 8'({S0, S1}), 8'd1);
        en_mask = 4'b0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mask0_busy", 8'(busy), 8'd0);
        check("mask0_sel", 8'({S0, S1}), 8'd1);

        // Skip and wrap: channels 1,3 with dwell=0 -> period 2.
        en_mask = 4'b1010;
        dwell   = 4'd0;
        mux_in  = 4'b0000;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s2_first_sel", 8'({S0, S1}), 8'd1);
        push(2'd1, 4'b1101);
        push(2'd3, 4'b0101);
        push(2'd1, 4'b0101);
        push(2'd3, 4'b0101);
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            check("s2_valid", 8'(sample_valid), 8'(cyc % 2 == 0));
            if (cyc % 2 == 0)
                check("s2_sel", 8'({S0, S1}), (cyc % 4 == 2) ? 8'd3 : 8'd1);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("s2_stop_busy", 8'(busy), 8'd0);

        // Single channel 2 with dwell=1 -> period 3, select never moves.
        en_mask = 4'b0100;
        dwell   = 4'd1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s3_first_sel", 8'({S0, S1}), 8'd2);
        push(2'd2, 4'b0001);
        push(2'd2, 4'b0001);
        push(2'd2, 4'b0001);
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            check("s3_valid", 8'(sample_valid), 8'(cyc % 3 == 0));
            check("s3_sel", 8'({S0, S1}), 8'd2);
        end

        // Mask cleared during SETTLE of ch2: one more capture, then IDLE.
        en_mask = 4'b0000;
        mux_in  = 4'b0100;
        push(2'd2, 4'b0101);
        @(negedge clk);
        check("s5_busy_a", 8'(busy), 8'd1);
        @(negedge clk);
        check("s5_busy_b", 8'(busy), 8'd1);
        @(negedge clk);
        check("s5_valid", 8'(sample_valid), 8'd1);
        check("s5_idle", 8'(busy), 8'd0);
        check("s5_bits", 8'(sample_bits), 8'b0101);
        @(negedge clk);
        check("s5_valid_drop", 8'(sample_valid), 8'd0);
        check("s5_stay_idle", 8'(busy), 8'd0);

        // Reset pulse mid-SETTLE, then restart from the lowest enabled channel.
        en_mask = 4'b0110;
        dwell   = 4'd3;
        mux_in  = 4'b0010;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s6_first_sel", 8'({S0, S1}), 8'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("s6_rst_busy", 8'(busy), 8'd0);
        check("s6_rst_sel", 8'({S0, S1}), 8'd0);
        check("s6_rst_valid", 8'(sample_valid), 8'd0);
        check("s6_rst_ch", 8'(sample_ch), 8'd0);
        check("s6_rst_bits", 8'(sample_bits), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("s6_wait_idle", 8'(busy), 8'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("s6_restart_sel", 8'({S0, S1}), 8'd1);
        push(2'd1, 4'b0010);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(negedge clk);
            check("s6_valid", 8'(sample_valid), 8'(cyc == 5));
        end
        check("s6_bits", 8'(sample_bits), 8'b0010);
        check("s6_next_sel", 8'({S0, S1}), 8'd2);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("s6_stop_busy", 8'(busy), 8'd0);

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_scanner.md
CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 Parameter: DWELL_W, default 4, width of the settle-time count.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  begins a scan when idle.
REQ-005 Port: stop  input  1  aborts a scan.
REQ-006 Port: en_mask  input  4  channel enables; bit n enables channel n.
REQ-007 Port: dwell  input  DWELL_W  settle cycles per channel, minus one.
REQ-008 Port: mux_out  input  1  output of the downstream 4:1 select mux.
REQ-009 Port: S0  output  1  mux select MSB; channel index = {S0,S1}.
REQ-010 Port: S1  output  1  mux select LSB.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: sample_valid  output  1  one-cycle strobe; a channel was captured.
REQ-013 Port: sample_ch  output  2  channel index of the latest capture.
REQ-014 Port: sample_bits  output  4  latest captured value per channel; bit n = channel n.

Function
REQ-015 States SHALL be IDLE, SETTLE and SAMPLE.
- IDLE -> SETTLE when start=1, stop=0 and en_mask!=0.
- SETTLE -> SAMPLE when the counter is 0.
- SAMPLE -> SETTLE.
REQ-016 On leaving IDLE, {S0,S1} SHALL take the lowest-numbered enabled channel, and the counter SHALL load dwell.
REQ-017 In SETTLE, the counter SHALL decrement each cycle; SETTLE lasts dwell+1 cycles, so dwell=0 gives 1 cycle.
REQ-018 In SAMPLE, sample_bits[ch] SHALL take mux_out, sample_ch SHALL take ch, sample_valid SHALL be 1 for that single cycle, and all other sample_bits SHALL hold.
REQ-019 In SAMPLE, the next channel SHALL be the first enabled index after ch in ascending order, wrapping 3->0. If ch is the only enabled channel, it is reselected. The counter SHALL reload dwell.
REQ-020 en_mask SHALL be sampled only at IDLE exit and in SAMPLE. If en_mask=0 in SAMPLE, the next state SHALL be IDLE (the capture still occurs).
REQ-021 stop=1 in SETTLE or SAMPLE SHALL force IDLE on the next edge.
- In SAMPLE, the capture is suppressed: no sample_valid, sample_bits unchanged.
- S0/S1 hold their last value.
REQ-022 stop SHALL win over start when both are high; start while busy SHALL be ignored.
REQ-023 start with en_mask=0 SHALL leave the block in IDLE with no output change.
REQ-024 The per-channel scan period SHALL be dwell+2 cycles, from select change to the next select change.
REQ-025 sample_bits SHALL persist across scans and stop; only reset clears them.

Reset
REQ-026 On rst_n low, immediately and independent of clk:
- state = IDLE; S0 = S1 = 0; busy = 0; sample_valid = 0; sample_ch = 0; sample_bits = 0; counter = 0.
REQ-027 Reset asserted mid-scan SHALL abort with no capture; after deassertion the block SHALL wait in IDLE for start.

Structure
REQ-028 A shared package scanner_pkg SHALL hold:
- the state enumeration;
- NUM_CH = 4;
- CH_W = 2.
REQ-029 The next-channel search SHALL be a combinational sub-module rr_next_ch with inputs cur_ch and en_mask, and outputs nxt_ch and any_en.
REQ-030 The block SHALL connect S0/S1 directly to the 4:1 mux selects, and mux_out directly from its output.

Verification
REQ-031 Mask and basic scan: dwell=2, en_mask=4'b1111, mux inputs I0..I3=1,0,1,1, start.
- Expected: selects 0,1,2,3,0.
- One sample_valid every 4 cycles.
- sample_bits=4'b1101 after the first pass.
REQ-032 Skip and wrap: en_mask=4'b1010, dwell=0 -> channel order 1,3,1,3; sample_valid every 2 cycles.
REQ-033 Single channel: en_mask=4'b0100 -> S0S1 stays 2'b10; sample_ch=2 on every strobe.
REQ-034 Abort and simultaneous start/stop:
- stop asserted in the SAMPLE cycle of ch1 -> no strobe, sample_bits[1] unchanged, IDLE next cycle.
- start and stop together in IDLE -> remain IDLE.
REQ-035 Mask cleared mid-scan: en_mask set to 0 during SETTLE of ch2 -> ch2 captured once, then IDLE with busy=0.
REQ-036 Reset mid-scan: rst_n pulsed low during SETTLE -> all outputs zero immediately; restart begins at the lowest enabled channel.
